if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port stall  input  1  ID stage cannot accept a new instruction this cycle.
REQ-005 SHALL have port flush  input  1  exception redirect; discard all fetched and in-flight work.
REQ-006 SHALL have port flush_pc  input  32  restart address on flush.
REQ-007 SHALL have port branch_flag  input  1  taken branch decoded in ID (combinational from ID).
REQ-008 SHALL have port branch_addr  input  32  branch target.
REQ-009 SHALL have port rom_en  output  1  instruction-memory request.
REQ-010 SHALL have port rom_addr  output  32  request address.
REQ-011 SHALL have port rom_ready  input  1  request complete; rom_data valid this cycle.
REQ-012 SHALL have port rom_data  input  32  fetched instruction.
REQ-013 SHALL have ports id_valid  output  1, id_pc  output  32, id_inst  output  32: registered instruction presented to ID.

Function
REQ-014 SHALL have one outstanding request at most; rom_addr SHALL stay constant while rom_en=1 until the cycle rom_ready=1.
REQ-015 SHALL implement states FETCH (rom_en=1, rom_addr=fetch_pc), HOLD (rom_en=0, fetched word buffered), DISCARD (rom_en=1, rom_addr held, result to be dropped).
REQ-016 FETCH: rom_ready=1 and stall=0 -> word loaded to ID register, fetch_pc advances, stay FETCH; rom_ready=1 and stall=1 -> word buffered, go HOLD; rom_ready=0 -> stay.
REQ-017 HOLD: stall=0 -> buffered word loaded to ID register, fetch_pc advances, go FETCH; stall=1 -> stay.
REQ-018 DISCARD: rom_ready=1 -> word dropped, fetch_pc=restart target, go FETCH next cycle; else stay.
REQ-019 ID register SHALL load only when stall=0; no word available -> id_valid=0 (bubble); stall=1 -> id_valid/id_pc/id_inst hold.
REQ-020 fetch_pc advance SHALL be fetch_pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), unless a branch redirect is pending.
REQ-021 branch_flag SHALL be sampled only when id_valid=1 and stall=0; fetch_pc is then the delay slot address, delivered normally.
REQ-022 Sampled branch, delay slot delivered same cycle -> fetch_pc=branch_addr directly; otherwise latch branch_addr as pending, and on delay-slot delivery fetch_pc=pending target, pending cleared.
REQ-023 flush=1 SHALL override stall and branch: next cycle id_valid=0, pending branch cleared, restart target=flush_pc.
REQ-024 flush in FETCH with rom_ready=1, or in HOLD -> word dropped, next state FETCH with fetch_pc=flush_pc.
REQ-025 flush in FETCH with rom_ready=0 -> DISCARD; flush in DISCARD -> restart target updated to newest flush_pc.
REQ-026 Instruction leaves fetch to ID exactly once; none duplicated or lost except by flush.
REQ-027 Latency: zero-wait rom (rom_ready in request cycle) -> one instruction per cycle, id_inst valid cycle after rom_ready.
REQ-028 Address low bits SHALL pass unmodified; alignment checking belongs to exception logic.

Reset
REQ-029 While rst=0: rom_en=0, rom_addr=0, id_valid=0, id_pc=0, id_inst=0, pending cleared, state FETCH, fetch_pc=RESET_PC.
REQ-030 First request SHALL appear first cycle after rst deasserts: rom_en=1, rom_addr=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon it immediately; outstanding rom_ready after reset release for a pre-reset request is outside scope (memory reset alongside).

Verification
REQ-032 Zero-wait rom, no stall: rom_addr 0,4,8,12 in consecutive cycles; id_pc 0,4,8 one cycle behind, id_valid=1 continuously.
REQ-033 stall=1 for 3 cycles while rom_ready=1 on addr 8 -> HOLD, rom_en=0, id_pc stays 4; stall release -> id_pc=8, next rom_addr=12.
REQ-034 Branch at id_pc=0x10 to 0x100, delay slot 0x14 ready same cycle -> id_pc 0x14 then 0x100; no 0x18 ever delivered.
REQ-035 Branch with rom 3-wait on delay slot -> bubbles, then id_pc 0x14, next rom_addr=0x100.
REQ-036 flush (flush_pc=0x180) during 2-wait request at 0x20 -> rom_addr stays 0x20 until rom_ready, word dropped, id_valid=0, next rom_addr=0x180.
REQ-037 rst pulse mid-stream -> outputs zero asynchronously; after release rom_addr=RESET_PC; fetch_pc=0xFFFFFFFC case wraps to 0.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with single outstanding rom request and registered ID hand-off
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic        rom_ready,
  input  logic [31:0] rom_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] restart_pc_q, restart_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        rom_en_q, rom_en_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic        word_avail;
  logic [31:0] word_data;
  logic        br_take;
  logic        deliver;
  logic [31:0] next_seq_pc;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    restart_pc_d = restart_pc_q;
    buf_inst_d   = buf_inst_q;
    br_pend_d    = br_pend_q;
    br_tgt_d     = br_tgt_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;
    word_avail   = 1'b0;
    word_data    = rom_data;

    // rom_en_q gates the first cycle after reset, when no request is yet on the bus
    unique case (state_q)
      S_FETCH: word_avail = rom_en_q && rom_ready;
      S_HOLD: begin
        word_avail = 1'b1;
        word_data  = buf_inst_q;
      end
      default: word_avail = 1'b0;
    endcase

    br_take = id_valid_q && !stall && branch_flag && !flush;
    deliver = word_avail && !stall && !flush;

    if (br_take) begin
      next_seq_pc = branch_addr;
    end else if (br_pend_q) begin
      next_seq_pc = br_tgt_q;
    end else begin
      next_seq_pc = fetch_pc_q + 32'd4;
    end

    if (flush) begin
      id_valid_d = 1'b0;
    end else if (!stall) begin
      id_valid_d = deliver;
      if (deliver) begin
        id_pc_d   = fetch_pc_q;
        id_inst_d = word_data;
      end
    end

    if (flush) begin
      br_pend_d = 1'b0;
      if (state_q == S_FETCH && rom_en_q && !rom_ready) begin
        state_d      = S_DISCARD;
        restart_pc_d = flush_pc;
      end else if (state_q == S_DISCARD && !rom_ready) begin
        restart_pc_d = flush_pc;
      end else begin
        state_d    = S_FETCH;
        fetch_pc_d = flush_pc;
      end
    end else begin
      if (deliver) begin
        state_d    = S_FETCH;
        fetch_pc_d = next_seq_pc;
        br_pend_d  = 1'b0;
      end else if (br_take) begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_addr;
      end

      if (state_q == S_FETCH && word_avail && stall) begin
        state_d    = S_HOLD;
        buf_inst_d = rom_data;
      end

      // the abandoned word is dropped; the request address stays put until it completes
      if (state_q == S_DISCARD && rom_ready) begin
        state_d    = S_FETCH;
        fetch_pc_d = restart_pc_q;
      end
    end

    rom_en_d   = (state_d != S_HOLD);
    rom_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      restart_pc_q <= RESET_PC;
      buf_inst_q   <= 32'd0;
      br_pend_q    <= 1'b0;
      br_tgt_q     <= 32'd0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= 32'd0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'd0;
      id_inst_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      restart_pc_q <= restart_pc_d;
      buf_inst_q   <= buf_inst_d;
      br_pend_q    <= br_pend_d;
      br_tgt_q     <= br_tgt_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized self-checking bench for if_fetch
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_flag, rom_en, rom_ready, id_valid;
  logic [31:0] flush_pc, branch_addr, rom_addr, rom_data, id_pc, id_inst;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pc;
  logic        tgt_v;
  logic [31:0] tgt;
  int          delivered = 0;
  int          lat_left = 0;
  int          fixed_lat = 0;
  bit          rand_lat = 0;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_ready(rom_ready), .rom_data(rom_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_rom();
    if (rom_en) begin
      if (lat_left == 0) begin
        rom_ready = 1'b1;
        rom_data  = mem(rom_addr);
      end else begin
        rom_ready = 1'b0;
        rom_data  = 32'hDEAD_BEEF;
        lat_left--;
      end
    end else begin
      rom_ready = 1'b0;
    end
  endtask

  // Program-order model: the next instruction ID must see, and a branch target armed for after the delay slot
  task automatic step();
    logic hs, br, fl, st;
    logic [31:0] fpc, ba;
    @(negedge clk);
    hs  = rom_en && rom_ready;
    fl  = flush;
    st  = stall;
    fpc = flush_pc;
    ba  = branch_addr;
    br  = id_valid && !stall && branch_flag && !flush;
    @(posedge clk);
    #1;
    if (fl) begin
      check("flush_bubble", {31'd0, id_valid}, 32'd0);
      exp_pc = fpc;
      tgt_v  = 1'b0;
    end else if (!st) begin
      if (br) begin
        tgt   = ba;
        tgt_v = 1'b1;
      end
      if (id_valid) begin
        check("seq_pc", id_pc, exp_pc);
        check("seq_inst", id_inst, mem(exp_pc));
        delivered++;
        exp_pc = tgt_v ? tgt : exp_pc + 32'd4;
        tgt_v  = 1'b0;
      end
    end
    if (hs) lat_left = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    drive_rom();
  endtask

  task automatic model_reset();
    exp_pc   = RST_PC;
    tgt_v    = 1'b0;
    tgt      = 32'd0;
    lat_left = 0;
  endtask

  initial begin
    logic [31:0] held_addr;
    logic        held;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    branch_flag = 1'b0; branch_addr = 32'd0; rom_ready = 1'b0; rom_data = 32'd0;
    model_reset();
    #2;
    check("rst_rom_en", {31'd0, rom_en}, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    step();
    check("first_req_en", {31'd0, rom_en}, 32'd1);
    check("first_req_addr", rom_addr, RST_PC);
    check("first_id_valid", {31'd0, id_valid}, 32'd0);
    step();
    check("zw_addr4", rom_addr, 32'h4);
    check("zw_id_pc0", id_pc, 32'h0);
    check("zw_id_valid", {31'd0, id_valid}, 32'd1);
    step();
    check("zw_addr8", rom_addr, 32'h8);
    check("zw_id_pc4", id_pc, 32'h4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_rom_en", {31'd0, rom_en}, 32'd0);
      check("hold_id_pc", id_pc, 32'h4);
      check("hold_id_valid", {31'd0, id_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    check("unhold_id_pc", id_pc, 32'h8);
    check("unhold_addr", rom_addr, 32'hC);
    check("unhold_en", {31'd0, rom_en}, 32'd1);
    step();
    step();
    check("pre_br_id_pc", id_pc, 32'h10);
    check("pre_br_addr", rom_addr, 32'h14);

    branch_flag = 1'b1; branch_addr = 32'h100;
    step();
    branch_flag = 1'b0;
    check("slot_id_pc", id_pc, 32'h14);
    check("br_target_addr", rom_addr, 32'h100);
    step();
    check("br_target_id_pc", id_pc, 32'h100);

    fixed_lat = 3;
    step();
    check("wait_slot_id_pc", id_pc, 32'h104);
    check("wait_slot_addr", rom_addr, 32'h108);
    branch_flag = 1'b1; branch_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      branch_flag = 1'b0;
      check("wait_bubble", {31'd0, id_valid}, 32'd0);
      check("wait_addr_stable", rom_addr, 32'h108);
    end
    fixed_lat = 2;
    step();
    check("wait_slot_done_pc", id_pc, 32'h108);
    check("wait_br_addr", rom_addr, 32'h200);

    flush = 1'b1; flush_pc = 32'h180; fixed_lat = 0;
    step();
    flush = 1'b0;
    check("disc_addr0", rom_addr, 32'h200);
    check("disc_en0", {31'd0, rom_en}, 32'd1);
    step();
    check("disc_addr1", rom_addr, 32'h200);
    check("disc_bubble1", {31'd0, id_valid}, 32'd0);
    step();
    check("disc_restart_addr", rom_addr, 32'h180);
    check("disc_dropped", {31'd0, id_valid}, 32'd0);
    step();
    check("disc_restart_pc", id_pc, 32'h180);

    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    step();
    flush = 1'b0;
    check("wrap_req", rom_addr, 32'hFFFF_FFF8);
    step();
    step();
    check("wrap_pc_fc", id_pc, 32'hFFFF_FFFC);
    check("wrap_addr0", rom_addr, 32'h0);
    step();
    check("wrap_pc0", id_pc, 32'h0);

    #3 rst = 1'b0;
    rom_ready = 1'b0;
    #1;
    check("async_rom_en", {31'd0, rom_en}, 32'd0);
    check("async_rom_addr", rom_addr, 32'd0);
    check("async_id_valid", {31'd0, id_valid}, 32'd0);
    check("async_id_pc", id_pc, 32'd0);
    check("async_id_inst", id_inst, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("rerst_en", {31'd0, rom_en}, 32'd1);
    check("rerst_addr", rom_addr, RST_PC);

    rand_lat = 1;
    for (int n = 0; n < 3000; n++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      flush_pc    = $urandom();
      branch_flag = id_valid && ($urandom_range(0, 7) == 0);
      branch_addr = $urandom();
      held        = rom_en && !rom_ready;
      held_addr   = rom_addr;
      step();
      if (held) begin
        check("req_en_stable", {31'd0, rom_en}, 32'd1);
        check("req_addr_stable", rom_addr, held_addr);
      end
    end
    stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    check("progress", {31'd0, delivered > 300}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
